// File: rtl/lcplc_band_sequencer_if.sv
// lcplc_band_sequencer_if: control-token and d_flag
// handshakes between the band sequencer and the error_calc path.
interface lcplc_band_sequencer_if;
  logic       ctrl_valid;
  logic       ctrl_ready;
  logic [3:0] ctrl_data;
  logic       d_flag_valid;
  logic       d_flag_ready;
  logic       d_flag_data;

  modport master (
    output ctrl_valid,
    output ctrl_data,
    output d_flag_ready,
    input  ctrl_ready,
    input  d_flag_valid,
    input  d_flag_data
  );

  modport slave (
    input  ctrl_valid,
    input  ctrl_data,
    input  d_flag_ready,
    output ctrl_ready,
    output d_flag_valid,
    output d_flag_data
  );
endinterface

// File: rtl/lcplc_band_sequencer.sv
// lcplc_band_sequencer: per-block band/sample token scheduler.
// Optional LCPLC_SEQ_SKIP_STATS_EN adds skip_count output.
module lcplc_band_sequencer #(
  parameter int BANDS          = 224,
  parameter int BLOCK_SIZE_LOG = 8,
  parameter int BLOCKS         = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  lcplc_band_sequencer_if.master    bus,
  output logic [$clog2(BANDS)-1:0]  band_index,
  output logic                      block_done,
  output logic                      busy
`ifdef LCPLC_SEQ_SKIP_STATS_EN
  ,
  output logic [$clog2(BANDS+1)-1:0] skip_count
`endif
);

  localparam int BW = $clog2(BANDS);
  localparam int SL = BLOCK_SIZE_LOG;
  localparam logic [BW-1:0] LAST_BAND = BW'(BANDS - 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ISSUE     = 2'd1;
  localparam logic [1:0] WAIT_FLAG = 2'd2;
  localparam logic [1:0] DONE      = 2'd3;

  logic [1:0]    state;
  logic [SL-1:0] sample;
  logic [BW-1:0] band;
  logic          ref_sel;
  logic [31:0]   blk_cnt;

  logic first_band;
  logic last_band;
  logic last_sample;
  logic quota_hit;
  logic quota_next;

  assign first_band  = (band == '0);
  assign last_band   = (band == LAST_BAND);
  assign last_sample = &sample;

  assign quota_hit  = (BLOCKS != 0) &&
                      (blk_cnt == 32'(BLOCKS));
  assign quota_next = (BLOCKS != 0) &&
                      ((blk_cnt + 32'd1) == 32'(BLOCKS));

  // Outputs decode straight from the registered state/counters
  always_comb begin
    bus.ctrl_valid   = (state == ISSUE);
    bus.d_flag_ready = (state == WAIT_FLAG);
    block_done       = (state == DONE);
    busy             = (state != IDLE);
    band_index       = band;
    bus.ctrl_data    = 4'h0;
    if (state == ISSUE) begin
      bus.ctrl_data = {ref_sel & ~first_band,
                       last_sample,
                       last_band,
                       first_band};
    end
  end

  // Band/sample walk; a band only starts once the previous flag is in
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sample  <= '0;
      band    <= '0;
      ref_sel <= 1'b0;
      blk_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && !quota_hit) begin
            state   <= ISSUE;
            band    <= '0;
            sample  <= '0;
            ref_sel <= 1'b0;
          end
        end
        ISSUE: begin
          if (bus.ctrl_ready) begin
            sample <= sample + 1'b1;
            if (last_sample) state <= WAIT_FLAG;
          end
        end
        WAIT_FLAG: begin
          if (bus.d_flag_valid) begin
            ref_sel <= bus.d_flag_data;
            if (last_band) begin
              state <= DONE;
            end else begin
              band  <= band + 1'b1;
              state <= ISSUE;
            end
          end
        end
        default: begin
          blk_cnt <= blk_cnt + 32'd1;
          band    <= '0;
          sample  <= '0;
          ref_sel <= 1'b0;
          if (quota_next || !enable) state <= IDLE;
          else                       state <= ISSUE;
        end
      endcase
    end
  end

`ifdef LCPLC_SEQ_SKIP_STATS_EN
  // Count skipped bands; value holds through the block_done cycle
  always_ff @(posedge clk) begin
    if (rst || state == DONE) begin
      skip_count <= '0;
    end else if (state == WAIT_FLAG && bus.d_flag_valid &&
                 !bus.d_flag_data) begin
      skip_count <= skip_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_lcplc_band_sequencer.sv
// tb_lcplc_band_sequencer: randomized traffic against a
// band/sample walk model for lcplc_band_sequencer.
module tb_lcplc_band_sequencer;

  localparam int BANDS = 3;
  localparam int BSL   = 2;
  localparam int BS    = 1 << BSL;
  localparam int NBLK  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [1:0] band_index;
  logic       block_done;
  logic       busy;
`ifdef LCPLC_SEQ_SKIP_STATS_EN
  logic [1:0] skip_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  lcplc_band_sequencer_if bus ();

  lcplc_band_sequencer #(
    .BANDS(BANDS),
    .BLOCK_SIZE_LOG(BSL),
    .BLOCKS(NBLK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .bus(bus),
    .band_index(band_index),
    .block_done(block_done),
    .busy(busy)
`ifdef LCPLC_SEQ_SKIP_STATS_EN
    ,
    .skip_count(skip_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    rst = 1'b1;
    enable = 1'b0;
    bus.ctrl_ready = 1'b0;
    bus.d_flag_valid = 1'b0;
    bus.d_flag_data = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b1;
    bus.ctrl_ready = 1'b1;
    bus.d_flag_valid = 1'b1;
    bus.d_flag_data = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.ctrl_valid, bus.d_flag_ready, block_done, busy} !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_flags got %b exp 0000",
               {bus.ctrl_valid, bus.d_flag_ready, block_done, busy});
    end
    vectors++;
    if (bus.ctrl_data !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_ctrl_data got %h exp 0", bus.ctrl_data);
    end
    vectors++;
    if (band_index !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_band_index got %0d exp 0", band_index);
    end
`ifdef LCPLC_SEQ_SKIP_STATS_EN
    vectors++;
    if (skip_count !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_skip_count got %0d exp 0", skip_count);
    end
`endif
    apply_reset();
  endtask

  // ph: 0 issuing tokens, 1 waiting flag, 2 done pulse, 3 idle
  task automatic run_traffic(input string nm,
                             input int rdy_pct,
                             input int dmin,
                             input int dmax,
                             input bit use_pat,
                             input logic [2:0] pat,
                             input bit drop_en,
                             input int exp_blocks);
    int ph = 0;
    int band = 0;
    int smp = 0;
    int blk = 0;
    int dly = 0;
    int cyc = 0;
    int idle_cyc = 0;
    int pulses = 0;
    int toks = 0;
    int skips = 0;
    bit stalled = 1'b0;
    bit flg [BANDS];
    logic [3:0] prev = 4'h0;
    logic [3:0] exp_tok;

    for (int i = 0; i < BANDS; i++)
      flg[i] = use_pat ? pat[i] : 1'($urandom_range(1));
    enable = 1'b1;
    bus.ctrl_ready = 1'b0;
    @(negedge clk);

    while (idle_cyc < 4 && cyc < 3000) begin
      cyc++;
      vectors++;
      if (bus.ctrl_valid !== (ph == 0)) begin
        miscompares++;
        $display("FAIL %s ctrl_valid cyc %0d got %b exp %b",
                 nm, cyc, bus.ctrl_valid, ph == 0);
      end
      vectors++;
      if (bus.d_flag_ready !== (ph == 1)) begin
        miscompares++;
        $display("FAIL %s d_flag_ready cyc %0d got %b exp %b",
                 nm, cyc, bus.d_flag_ready, ph == 1);
      end
      vectors++;
      if (block_done !== (ph == 2)) begin
        miscompares++;
        $display("FAIL %s block_done cyc %0d got %b exp %b",
                 nm, cyc, block_done, ph == 2);
      end
      vectors++;
      if (busy !== (ph != 3)) begin
        miscompares++;
        $display("FAIL %s busy cyc %0d got %b exp %b",
                 nm, cyc, busy, ph != 3);
      end
      if (ph < 2) begin
        vectors++;
        if (band_index !== 2'(band)) begin
          miscompares++;
          $display("FAIL %s band_index cyc %0d got %0d exp %0d",
                   nm, cyc, band_index, band);
        end
      end
      if (ph == 0) begin
        exp_tok[0] = (band == 0);
        exp_tok[1] = (band == BANDS - 1);
        exp_tok[2] = (smp == BS - 1);
        exp_tok[3] = 1'b0;
        if (band != 0) exp_tok[3] = flg[band-1];
        vectors++;
        if (bus.ctrl_data !== exp_tok) begin
          miscompares++;
          $display("FAIL %s ctrl_data blk %0d band %0d smp %0d got %h exp %h",
                   nm, blk, band, smp, bus.ctrl_data, exp_tok);
        end
        if (stalled) begin
          vectors++;
          if (bus.ctrl_data !== prev) begin
            miscompares++;
            $display("FAIL %s stall_hold got %h exp %h",
                     nm, bus.ctrl_data, prev);
          end
        end
        prev = bus.ctrl_data;
      end
`ifdef LCPLC_SEQ_SKIP_STATS_EN
      if (ph == 2) begin
        vectors++;
        if (skip_count !== 2'(skips)) begin
          miscompares++;
          $display("FAIL %s skip_count got %0d exp %0d",
                   nm, skip_count, skips);
        end
      end
`endif

      if (drop_en && blk == 0 && band == 1) enable = 1'b0;
      bus.ctrl_ready = ($urandom_range(99) < rdy_pct);
      bus.d_flag_valid = 1'b0;
      bus.d_flag_data = 1'($urandom_range(1));
      if (ph == 1) begin
        if (dly == 0) begin
          bus.d_flag_valid = 1'b1;
          bus.d_flag_data = flg[band];
        end else begin
          dly--;
        end
      end

      stalled = 1'b0;
      case (ph)
        0: begin
          if (bus.ctrl_ready) begin
            toks++;
            if (smp == BS - 1) begin
              smp = 0;
              ph = 1;
              dly = $urandom_range(dmax, dmin);
            end else begin
              smp++;
            end
          end else begin
            stalled = 1'b1;
          end
        end
        1: begin
          if (bus.d_flag_valid) begin
            if (!flg[band]) skips++;
            if (band == BANDS - 1) ph = 2;
            else begin
              band++;
              ph = 0;
            end
          end
        end
        2: begin
          pulses++;
          blk++;
          band = 0;
          skips = 0;
          if (blk == NBLK || !enable) ph = 3;
          else begin
            ph = 0;
            for (int i = 0; i < BANDS; i++)
              flg[i] = use_pat ? pat[i] : 1'($urandom_range(1));
          end
        end
        default: idle_cyc++;
      endcase
      @(negedge clk);
    end

    vectors++;
    if (cyc >= 3000) begin
      miscompares++;
      $display("FAIL %s timeout cyc %0d exp <3000", nm, cyc);
    end
    vectors++;
    if (pulses != exp_blocks) begin
      miscompares++;
      $display("FAIL %s block_count got %0d exp %0d",
               nm, pulses, exp_blocks);
    end
    vectors++;
    if (toks != exp_blocks * BANDS * BS) begin
      miscompares++;
      $display("FAIL %s token_count got %0d exp %0d",
               nm, toks, exp_blocks * BANDS * BS);
    end
    enable = 1'b0;
    bus.ctrl_ready = 1'b0;
    bus.d_flag_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    run_traffic("b2b_pattern", 100, 0, 0, 1'b1, 3'b110, 1'b0, NBLK);
  endtask

  task automatic test_random_flags();
    apply_reset();
    run_traffic("rand_flags", 100, 0, 3, 1'b0, 3'b000, 1'b0, NBLK);
  endtask

  task automatic test_stall();
    apply_reset();
    run_traffic("stall", 50, 0, 2, 1'b0, 3'b000, 1'b0, NBLK);
  endtask

  task automatic test_flag_delay();
    apply_reset();
    run_traffic("flag_delay", 100, 20, 20, 1'b0, 3'b000, 1'b0, NBLK);
  endtask

  task automatic test_enable_drop();
    apply_reset();
    run_traffic("enable_drop", 70, 0, 2, 1'b0, 3'b000, 1'b1, 1);
  endtask

  task automatic test_mid_reset();
    int cnt = 0;
    bit hit = 1'b0;
    apply_reset();
    enable = 1'b1;
    bus.ctrl_ready = 1'b1;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      if (bus.ctrl_valid && cnt == BS + 2) begin
        hit = 1'b1;
      end else begin
        bus.d_flag_valid = bus.d_flag_ready;
        bus.d_flag_data = 1'b1;
        if (bus.ctrl_valid) cnt++;
      end
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("FAIL mid_reset_reach tokens %0d exp %0d", cnt, BS + 2);
    end
    vectors++;
    if (band_index !== 2'd1 || bus.ctrl_data !== 4'h8) begin
      miscompares++;
      $display("FAIL mid_reset_pos band %0d data %h exp band 1 data 8",
               band_index, bus.ctrl_data);
    end
    rst = 1'b1;
    bus.d_flag_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus.ctrl_valid, bus.d_flag_ready, block_done, busy,
         bus.ctrl_data, band_index} !== 10'h0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs got %b exp 0",
               {bus.ctrl_valid, bus.d_flag_ready, block_done, busy,
                bus.ctrl_data, band_index});
    end
    rst = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.ctrl_valid !== 1'b1 || bus.ctrl_data !== 4'h1) begin
      miscompares++;
      $display("FAIL mid_reset_restart valid %b data %h exp 1 1",
               bus.ctrl_valid, bus.ctrl_data);
    end
    vectors++;
    if (band_index !== 2'd0) begin
      miscompares++;
      $display("FAIL mid_reset_band got %0d exp 0", band_index);
    end
    enable = 1'b0;
    bus.ctrl_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_random_flags();
    test_stall();
    test_flag_delay();
    test_enable_drop();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
